// File: rtl/div_seq_pkg.sv
// ---------------------------------------------------------------------------
// div_seq_pkg : shared types and constants for the sequential divider
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package div_seq_pkg;

  localparam int REG_W  = 32;
  localparam int DREG_W = 64;

  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;
  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;

  localparam logic [REG_W-1:0] ZERO_WORD = '0;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

  function automatic logic [REG_W-1:0] neg_if(input logic neg, input logic [REG_W-1:0] v);
    return neg ? (~v + 1'b1) : v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/div_step.sv
// ---------------------------------------------------------------------------
// div_step : one restoring-division step (trial subtract, keep or restore)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module div_step
  import div_seq_pkg::*;
(
  input  logic [REG_W-1:0] rem_i,
  input  logic [REG_W-1:0] divisor_i,
  output logic [REG_W-1:0] rem_o,
  output logic             q_bit_o
);

  logic [REG_W:0] w_diff;

  assign w_diff  = {1'b0, rem_i} - {1'b0, divisor_i};
  assign q_bit_o = ~w_diff[REG_W];
  assign rem_o   = q_bit_o ? w_diff[REG_W-1:0] : rem_i;

endmodule

`default_nettype wire

// File: rtl/div_seq.sv
// ---------------------------------------------------------------------------
// div_seq : 32-bit radix-2 restoring divider, result = {remainder, quotient}
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module div_seq
  import div_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              signed_div_i,
  input  logic [REG_W-1:0]  opdata1_i,
  input  logic [REG_W-1:0]  opdata2_i,
  input  logic              start_i,
  input  logic              annul_i,
  output logic [DREG_W-1:0] result_o,
  output logic              ready_o
);

  div_state_e        r_state, w_state_next;
  logic [5:0]        r_cnt, w_cnt_next;
  logic [63:0]       r_dividend, w_dividend_next;
  logic [REG_W-1:0]  r_divisor, w_divisor_next;
  logic              r_neg_quot, w_neg_quot_next;
  logic              r_neg_rem, w_neg_rem_next;
  logic [DREG_W-1:0] w_result_next;
  logic              w_ready_next;

  logic [REG_W-1:0]  w_rem_next;
  logic              w_q_bit;
  logic              w_neg1, w_neg2;

  div_step u_step (
    .rem_i     (r_dividend[63:32]),
    .divisor_i (r_divisor),
    .rem_o     (w_rem_next),
    .q_bit_o   (w_q_bit)
  );

  assign w_neg1 = signed_div_i & opdata1_i[REG_W-1];
  assign w_neg2 = signed_div_i & opdata2_i[REG_W-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= DIV_FREE;
      r_cnt      <= '0;
      r_dividend <= '0;
      r_divisor  <= '0;
      r_neg_quot <= 1'b0;
      r_neg_rem  <= 1'b0;
      result_o   <= '0;
      ready_o    <= DIV_RESULT_NOT_READY;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_dividend <= w_dividend_next;
      r_divisor  <= w_divisor_next;
      r_neg_quot <= w_neg_quot_next;
      r_neg_rem  <= w_neg_rem_next;
      result_o   <= w_result_next;
      ready_o    <= w_ready_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_cnt_next      = r_cnt;
    w_dividend_next = r_dividend;
    w_divisor_next  = r_divisor;
    w_neg_quot_next = r_neg_quot;
    w_neg_rem_next  = r_neg_rem;
    w_result_next   = result_o;
    w_ready_next    = ready_o;

    case (r_state)
      DIV_FREE: begin
        w_ready_next = DIV_RESULT_NOT_READY;
        if (start_i == DIV_START && !annul_i) begin
          if (opdata2_i == ZERO_WORD) begin
            w_state_next = DIV_BY_ZERO;
          end else begin
            // Low 64 bits of {32'b0, |op1|, 1'b0}; the top bit is never needed
            w_dividend_next = {31'b0, neg_if(w_neg1, opdata1_i), 1'b0};
            w_divisor_next  = neg_if(w_neg2, opdata2_i);
            w_neg_quot_next = w_neg1 ^ w_neg2;
            w_neg_rem_next  = w_neg1;
            w_cnt_next      = '0;
            w_state_next    = DIV_ON;
          end
        end
      end

      DIV_BY_ZERO: begin
        w_dividend_next = '0;
        w_result_next   = '0;
        w_state_next    = DIV_END;
      end

      DIV_ON: begin
        if (annul_i) begin
          w_state_next  = DIV_FREE;
          w_result_next = '0;
        end else begin
          w_dividend_next = {w_rem_next[REG_W-2:0], r_dividend[31:0], w_q_bit};
          w_cnt_next      = r_cnt + 6'd1;
          if (r_cnt == 6'd31) begin
            w_result_next = {neg_if(r_neg_rem, w_rem_next),
                             neg_if(r_neg_quot, {r_dividend[30:0], w_q_bit})};
            w_state_next  = DIV_END;
          end
        end
      end

      DIV_END: begin
        if (annul_i || start_i == DIV_STOP) begin
          w_state_next  = DIV_FREE;
          w_ready_next  = DIV_RESULT_NOT_READY;
          w_result_next = '0;
        end else begin
          w_ready_next = DIV_RESULT_READY;
        end
      end

      default: w_state_next = DIV_FREE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_div_seq.sv
// ---------------------------------------------------------------------------
// tb_div_seq : directed self-checking bench for div_seq
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_div_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div_seq dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents an operation before edge T and returns just after edge T,
  // then scrambles the operands to show they are no longer looked at.
  task automatic launch(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    @(posedge clk);
    #1;
    opdata1_i    = $urandom;
    opdata2_i    = $urandom;
    signed_div_i = ~sgn;
  endtask

  task automatic wait_ready(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!ready_o && lat < 40);
  endtask

  task automatic run_op(input string tag, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat, input logic [63:0] exp_res);
    int lat;
    launch(sgn, a, b);
    wait_ready(lat);
    chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, " result"}, result_o, exp_res);
  endtask

  task automatic release_start(input string tag);
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, " ready cleared"}, {63'b0, ready_o}, 64'd0);
    chk({tag, " result cleared"}, result_o, 64'd0);
  endtask

  initial begin
    logic saw_ready;
    logic [63:0] held;

    rst          = 1'b1;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i    = '0;
    opdata2_i    = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset ready", {63'b0, ready_o}, 64'd0);
    chk("reset result", result_o, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("divu 100/7", 1'b0, 32'd100, 32'd7, 33, 64'h00000002_0000000E);
    release_start("divu 100/7");
    run_op("div -100/7", 1'b1, 32'hFFFFFF9C, 32'd7, 33, 64'hFFFFFFFE_FFFFFFF2);
    release_start("div -100/7");
    run_op("div 100/-7", 1'b1, 32'd100, 32'hFFFFFFF9, 33, 64'h00000002_FFFFFFF2);
    release_start("div 100/-7");
    run_op("div -7/-2", 1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 33, 64'hFFFFFFFF_00000003);
    release_start("div -7/-2");
    run_op("divu big", 1'b0, 32'hFFFFFFFF, 32'h80000001, 33, 64'h7FFFFFFE_00000001);
    release_start("divu big");

    run_op("div 5/0", 1'b1, 32'd5, 32'd0, 2, 64'h0);
    release_start("div 5/0");

    // Flush partway through; the result must never be reported
    launch(1'b0, 32'd1234, 32'd5);
    repeat (8) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1;
    start_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    annul_i   = 1'b0;
    saw_ready = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (ready_o) saw_ready = 1'b1;
    end
    chk("annul no ready", {63'b0, saw_ready}, 64'd0);
    chk("annul result", result_o, 64'd0);
    run_op("divu ffffffff/1", 1'b0, 32'hFFFFFFFF, 32'd1, 33, 64'h00000000_FFFFFFFF);
    release_start("divu ffffffff/1");

    // Async reset while a result is being held
    run_op("divu 100/7 pre-rst", 1'b0, 32'd100, 32'd7, 33, 64'h00000002_0000000E);
    #3;
    rst = 1'b1;
    #1;
    chk("rst in end ready", {63'b0, ready_o}, 64'd0);
    chk("rst in end result", result_o, 64'd0);
    start_i = 1'b0;
    #1;
    rst = 1'b0;

    // Async reset mid-operation
    launch(1'b0, 32'd100, 32'd7);
    repeat (19) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("rst mid ready", {63'b0, ready_o}, 64'd0);
    chk("rst mid result", result_o, 64'd0);
    start_i = 1'b0;
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    run_op("divu 100/7 post-rst", 1'b0, 32'd100, 32'd7, 33, 64'h00000002_0000000E);
    release_start("divu 100/7 post-rst");

    run_op("div min/-1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 33, 64'h00000000_80000000);
    held = result_o;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("hold ready", {63'b0, ready_o}, 64'd1);
      chk("hold result", result_o, 64'h00000000_80000000);
    end
    chk("hold unchanged", result_o, held);
    release_start("div min/-1");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
